// File: rtl/es7243e_i2c_cfg.sv
// -----------------------------------------------------------------------------
// es7243e_i2c_cfg
// Write-only I2C master that programs the ES7243E ADC codec from a small
// register ROM once after reset and then raises a sticky completion flag.
// Each ROM entry is sent as one frame: START, device address (write),
// register address, register data, STOP, then a short idle gap.
//
// Ports
//   clk_12M        in    12.288 MHz system clock
//   rst            in    asynchronous active-high reset
//   i2c_sclk       out   SCL, push-pull, idles high
//   i2c_sdat       inout SDA, open-drain (drives 0 or z only)
//   reg_conf_done  out   high once every ROM entry is written; sticky until rst
//   clock_i2c      out   free-running 50% clock at the SCL bit rate
//
// Configuration
//   I2C_ACK_CHECK_EN  when defined, a NACK ends the frame with STOP and the
//                     same entry is retried; otherwise ACK slots are ignored.
// -----------------------------------------------------------------------------
module es7243e_i2c_cfg #(
   parameter int         QDIV     = 30,
   parameter logic [6:0] DEV_ADDR = 7'h10,
   parameter int         REG_NUM  = 8
) (
   input  logic clk_12M,
   input  logic rst,
   output logic i2c_sclk,
   inout  wire  i2c_sdat,
   output logic reg_conf_done,
   output logic clock_i2c
);

   localparam int QW = (QDIV > 1) ? $clog2(QDIV) : 1;
   localparam int CW = $clog2(2 * QDIV);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_ADDR, S_REG, S_DATA, S_STOP, S_GAP, S_DONE
   } state_t;

   state_t        state, n_state;
   logic [QW-1:0] qcnt;
   logic          tick;
   logic [CW-1:0] ccnt;
   logic [1:0]    q, n_q;          // quarter within the current slot
   logic [3:0]    bit_idx, n_bit;  // 0..7 data bits, 8 = ACK slot
   logic [3:0]    idx, n_idx;      // ROM entry being sent
   logic          sda_rel;         // 1 = SDA released
   logic          nack;
   logic [7:0]    n_byte;
   logic          n_scl, n_sda_rel;

   // NOTE: the ROM is a constant function, not a storage array, so there is
   // nothing to reset and it maps to plain logic.
   function automatic logic [15:0] rom_entry(input logic [2:0] i);
      case (i)
         3'd0:    rom_entry = 16'h0080;
         3'd1:    rom_entry = 16'h013A;
         3'd2:    rom_entry = 16'h0242;
         3'd3:    rom_entry = 16'h0310;
         3'd4:    rom_entry = 16'h0D01;
         3'd5:    rom_entry = 16'h0E01;
         3'd6:    rom_entry = 16'h203E;
         default: rom_entry = 16'h0001;
      endcase
   endfunction

   function automatic logic [7:0] byte_of(input state_t s, input logic [3:0] i);
      logic [15:0] e;
      e = rom_entry(i[2:0]);
      case (s)
         S_ADDR:  byte_of = {DEV_ADDR, 1'b0};
         S_REG:   byte_of = e[15:8];
         S_DATA:  byte_of = e[7:0];
         default: byte_of = 8'h00;
      endcase
   endfunction

   assign tick     = (qcnt == QW'(QDIV - 1));
   assign i2c_sdat = sda_rel ? 1'bz : 1'b0;

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk_12M or posedge rst) begin
      if (rst)       qcnt <= '0;
      else if (tick) qcnt <= '0;
      else           qcnt <= qcnt + QW'(1);
   end

   // Bit-rate clock, independent of the FSM: toggles every half bit.
   always_ff @(posedge clk_12M or posedge rst) begin
      if (rst) begin
         ccnt      <= '0;
         clock_i2c <= 1'b0;
      end else if (ccnt == CW'(2 * QDIV - 1)) begin
         ccnt      <= '0;
         clock_i2c <= ~clock_i2c;
      end else begin
         ccnt <= ccnt + CW'(1);
      end
   end

   // Next position in the frame, evaluated every cycle, committed on tick.
   // NOTE: every output gets a default first so no latch is inferred.
   always_comb begin
      n_state = state;
      n_q     = q + 2'd1;
      n_bit   = bit_idx;
      n_idx   = idx;
      case (state)
         S_IDLE:  if (q == 2'd3) n_state = S_START;
         S_START: if (q == 2'd3) begin
            n_state = S_ADDR;
            n_bit   = 4'd0;
         end
         S_ADDR, S_REG, S_DATA: if (q == 2'd3) begin
            if (bit_idx == 4'd8) begin
               n_bit = 4'd0;
               if (nack || state == S_DATA) n_state = S_STOP;
               else if (state == S_ADDR)    n_state = S_REG;
               else                         n_state = S_DATA;
            end else begin
               n_bit = bit_idx + 4'd1;
            end
         end
         S_STOP:  if (q == 2'd3) n_state = S_GAP;
         S_GAP:   if (q == 2'd3) begin
            if (nack) begin
               n_state = S_START;  // retry the same entry
            end else begin
               n_idx   = idx + 4'd1;
               n_state = (idx + 4'd1 == 4'(REG_NUM)) ? S_DONE : S_START;
            end
         end
         default: n_state = S_DONE;
      endcase
   end

   // Line levels for the upcoming quarter; registered on tick.
   always_comb begin
      n_byte    = byte_of(n_state, n_idx);
      n_scl     = 1'b1;
      n_sda_rel = 1'b1;
      case (n_state)
         S_START: n_sda_rel = ~n_q[1];
         S_ADDR, S_REG, S_DATA: begin
            n_scl     = n_q[1];
            n_sda_rel = (n_bit == 4'd8) ? 1'b1 : n_byte[3'd7 - n_bit[2:0]];
         end
         S_STOP: begin
            n_scl     = n_q[1];
            n_sda_rel = (n_q == 2'd3);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_12M or posedge rst) begin
      if (rst) begin
         state         <= S_IDLE;
         q             <= 2'd0;
         bit_idx       <= 4'd0;
         idx           <= 4'd0;
         i2c_sclk      <= 1'b1;
         sda_rel       <= 1'b1;
         reg_conf_done <= 1'b0;
`ifdef I2C_ACK_CHECK_EN
         nack          <= 1'b0;
`endif
      end else if (tick) begin
         state    <= n_state;
         q        <= n_q;
         bit_idx  <= n_bit;
         idx      <= n_idx;
         i2c_sclk <= n_scl;
         sda_rel  <= n_sda_rel;
         if (n_state == S_DONE) reg_conf_done <= 1'b1;
`ifdef I2C_ACK_CHECK_EN
         // ACK is sampled at the end of q2 of the ninth slot; sticky per frame.
         if (state == S_START)
            nack <= 1'b0;
         else if ((state == S_ADDR || state == S_REG || state == S_DATA) &&
                  q == 2'd2 && bit_idx == 4'd8 && i2c_sdat)
            nack <= 1'b1;
`endif
      end
   end

`ifndef I2C_ACK_CHECK_EN
   assign nack = 1'b0;
`endif

endmodule

// File: tb/tb_es7243e_i2c_cfg.sv
// -----------------------------------------------------------------------------
// tb_es7243e_i2c_cfg
// Directed bench for es7243e_i2c_cfg: a bus monitor decodes frames and
// measures SCL / clock_i2c timing, a slave model ACKs every byte (with one
// optional NACK), and a linear sequence covers reset values, an abort in
// entry 4, a full configuration run and the idle bus after completion.
// Expectations follow I2C_ACK_CHECK_EN when it is defined.
// -----------------------------------------------------------------------------
module tb_es7243e_i2c_cfg;

   logic clk_12M;
   logic rst;
   logic i2c_sclk;
   logic reg_conf_done;
   logic clock_i2c;
   wire  sda;
   logic slave_low;

   pullup (sda);
   assign sda = slave_low ? 1'b0 : 1'bz;

   es7243e_i2c_cfg dut (
      .clk_12M      (clk_12M),
      .rst          (rst),
      .i2c_sclk     (i2c_sclk),
      .i2c_sdat     (sda),
      .reg_conf_done(reg_conf_done),
      .clock_i2c    (clock_i2c)
   );

   initial clk_12M = 1'b0;
   always #5 clk_12M = ~clk_12M;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------- bus monitor + slave ----------------
   logic        scl_p = 1'b1, sda_p = 1'b1, ck_p = 1'b0;
   int          cyc = 0;
   int          in_frame = 0, bitcnt = 0, byte_idx = 0;
   logic [7:0]  sh = 8'h00;
   logic [7:0]  fb [3];
   logic [31:0] fr [0:63];
   int          frame_count = 0;
   int          perr = 0;
   int          last_rise = -1, last_ck_rise = -1;
   int          sp_min = 1 << 30, sp_max = 0, sh_min = 1 << 30, sh_max = 0;
   int          cp_min = 1 << 30, cp_max = 0, ch_min = 1 << 30, ch_max = 0;
   logic        nack_req = 1'b0;
   logic        nack_done = 1'b0;

   initial slave_low = 1'b0;

   always @(negedge clk_12M) begin
      logic s, d;
      cyc++;
      s = i2c_sclk;
      d = sda;
      if (rst) begin
         in_frame     = 0;
         bitcnt       = 0;
         byte_idx     = 0;
         last_rise    = -1;
         last_ck_rise = -1;
         slave_low    = 1'b0;
      end else begin
         if (scl_p && s && sda_p && !d) begin                // START
            if (in_frame != 0) perr++;
            in_frame  = 1;
            bitcnt    = 0;
            byte_idx  = 0;
            last_rise = -1;
            for (int i = 0; i < 3; i++) fb[i] = 8'h00;
         end else if (scl_p && s && !sda_p && d) begin       // STOP
            // the STOP's own SCL rise was counted as one bit
            if (in_frame == 0 || bitcnt != 1) perr++;
            else if (frame_count < 64) begin
               fr[frame_count] = {8'(byte_idx), fb[0], fb[1], fb[2]};
               frame_count++;
            end
            in_frame = 0;
         end else if (!scl_p && s && in_frame != 0) begin    // SCL rise
            if (last_rise >= 0) begin
               if (cyc - last_rise < sp_min) sp_min = cyc - last_rise;
               if (cyc - last_rise > sp_max) sp_max = cyc - last_rise;
            end
            last_rise = cyc;
            if (bitcnt < 8) begin
               sh = {sh[6:0], d};
               bitcnt++;
               if (bitcnt == 8 && byte_idx < 3) fb[byte_idx] = sh;
            end else begin
               bitcnt = 0;
               byte_idx++;
            end
         end else if (scl_p && !s && in_frame != 0) begin    // SCL fall
            if (last_rise >= 0) begin
               if (cyc - last_rise < sh_min) sh_min = cyc - last_rise;
               if (cyc - last_rise > sh_max) sh_max = cyc - last_rise;
            end
            if (bitcnt == 8) begin
               if (byte_idx == 1 && fb[1] == 8'h02 && nack_req && !nack_done)
                  nack_done = 1'b1;
               else
                  slave_low = 1'b1;
            end else if (bitcnt == 0) begin
               slave_low = 1'b0;
            end
         end
         if (!ck_p && clock_i2c) begin
            if (last_ck_rise >= 0) begin
               if (cyc - last_ck_rise < cp_min) cp_min = cyc - last_ck_rise;
               if (cyc - last_ck_rise > cp_max) cp_max = cyc - last_ck_rise;
            end
            last_ck_rise = cyc;
         end
         if (ck_p && !clock_i2c && last_ck_rise >= 0) begin
            if (cyc - last_ck_rise < ch_min) ch_min = cyc - last_ck_rise;
            if (cyc - last_ck_rise > ch_max) ch_max = cyc - last_ck_rise;
         end
      end
      scl_p = s;
      sda_p = d;
      ck_p  = clock_i2c;
   end

   // ---------------- directed sequence ----------------
   localparam logic [15:0] ROM [8] = '{16'h0080, 16'h013A, 16'h0242, 16'h0310,
                                      16'h0D01, 16'h0E01, 16'h203E, 16'h0001};

   logic [31:0] exp_fr [0:15];
   int          exp_n;
   int          base;
   int          frames_seen;
   int          bad_idle;
   logic        hit;

   initial begin
      exp_n = 0;
      for (int i = 0; i < 8; i++) begin
`ifdef I2C_ACK_CHECK_EN
         if (i == 2) begin
            exp_fr[exp_n] = {8'd2, 8'h20, ROM[i][15:8], 8'h00};
            exp_n++;
         end
`endif
         exp_fr[exp_n] = {8'd3, 8'h20, ROM[i]};
         exp_n++;
      end

      // reset values, and clock_i2c frozen while rst is held
      rst = 1'b1;
      repeat (200) @(posedge clk_12M);
      #1;
      check("rst_scl",  32'(i2c_sclk), 32'd1);
      check("rst_sda",  32'(sda), 32'd1);
      check("rst_done", 32'(reg_conf_done), 32'd0);
      check("rst_ck",   32'(clock_i2c), 32'd0);

      // first run: ACK everything, abort inside entry 4's DATA byte
      @(posedge clk_12M); #2;
      rst  = 1'b0;
      base = frame_count;
      hit  = 1'b0;
      for (int c = 0; c < 8000 && !hit; c++) begin
         @(posedge clk_12M);
         hit = (frame_count - base >= 1);
      end
      check("first_frame_seen", 32'(hit), 32'd1);
      check("first_frame", fr[base], {8'd3, 8'h20, 8'h00, 8'h80});

      hit = 1'b0;
      for (int c = 0; c < 30000 && !hit; c++) begin
         @(posedge clk_12M);
         hit = (frame_count - base == 4) && (in_frame != 0) && (byte_idx == 2) && (bitcnt >= 3);
      end
      check("reach_entry4_data", 32'(hit), 32'd1);
      check("done_mid_run", 32'(reg_conf_done), 32'd0);
      #2;
      rst = 1'b1;
      #1;
      check("abort_scl",  32'(i2c_sclk), 32'd1);
      check("abort_sda",  32'(sda), 32'd1);
      check("abort_done", 32'(reg_conf_done), 32'd0);

      // second run: restart from entry 0, one NACK on the REG byte of entry 2
      repeat (10) @(posedge clk_12M);
      #2;
      nack_req = 1'b1;
      base     = frame_count;
      rst      = 1'b0;
      hit      = 1'b0;
      for (int c = 0; c < 40000 && !hit; c++) begin
         @(posedge clk_12M);
         hit = reg_conf_done;
      end
      #1;
      check("done_reached", 32'(hit), 32'd1);
      frames_seen = frame_count - base;
      check("frame_count", 32'(frames_seen), 32'(exp_n));
      for (int i = 0; i < exp_n && i < frames_seen; i++)
         check($sformatf("frame%0d", i), fr[base + i], exp_fr[i]);
      check("nack_used", 32'(nack_done), 32'd1);

      check("scl_period_min", 32'(sp_min), 32'd120);
      check("scl_period_max", 32'(sp_max), 32'd120);
      check("scl_high_min",   32'(sh_min), 32'd60);
      check("scl_high_max",   32'(sh_max), 32'd60);
      check("ck_period_min",  32'(cp_min), 32'd120);
      check("ck_period_max",  32'(cp_max), 32'd120);
      check("ck_high_min",    32'(ch_min), 32'd60);
      check("ck_high_max",    32'(ch_max), 32'd60);
      check("protocol_errors", 32'(perr), 32'd0);

      // idle bus after completion
      base     = frame_count;
      bad_idle = 0;
      for (int c = 0; c < 4800; c++) begin
         @(posedge clk_12M); #1;
         if (i2c_sclk !== 1'b1 || sda !== 1'b1 || reg_conf_done !== 1'b1) bad_idle++;
      end
      check("idle_violations", 32'(bad_idle), 32'd0);
      check("idle_frames", 32'(frame_count - base), 32'd0);
      check("done_sticky", 32'(reg_conf_done), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
